// File: rtl/hdmi_mm_arbiter.sv
// hdmi_mm_arbiter: round-robin arbiter between host (A) and fill engine (B)
// in front of the HDMI MM slave; one outstanding transfer, read timeout.
module hdmi_mm_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                a_read,
  input  logic                a_write,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W-1:0]   a_writedata,
  input  logic [DATA_W/8-1:0] a_byteenable,
  output logic                a_waitrequest,
  output logic                a_readdatavalid,
  output logic [DATA_W-1:0]   a_readdata,
  input  logic                b_read,
  input  logic                b_write,
  input  logic [ADDR_W-1:0]   b_address,
  input  logic [DATA_W-1:0]   b_writedata,
  input  logic [DATA_W/8-1:0] b_byteenable,
  output logic                b_waitrequest,
  output logic                b_readdatavalid,
  output logic [DATA_W-1:0]   b_readdata,
  output logic                slave_read,
  output logic                slave_write,
  output logic [ADDR_W-1:0]   slave_address,
  output logic [DATA_W-1:0]   slave_writedata,
  output logic [DATA_W/8-1:0] slave_byteenable,
  output logic                slave_burstcount,
  input  logic                slave_waitrequest,
  input  logic                slave_readdatavalid,
  input  logic [DATA_W-1:0]   slave_readdata,
  output logic                rd_timeout_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] FILL     = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RDWAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_grant;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic              w_a_req;
  logic              w_b_req;
  logic              w_pick;
  logic              w_g_read;
  logic              w_g_write;
  logic [ADDR_W-1:0] w_g_addr;
  logic [DATA_W-1:0] w_g_wdata;
  logic [BE_W-1:0]   w_g_be;
  logic              w_in_bus;
  logic              w_in_rd;
  logic              w_ack;
  logic              w_tmo;
  logic              w_rsp;
  logic [DATA_W-1:0] w_rdata;

  assign w_a_req = a_read | a_write;
  assign w_b_req = b_read | b_write;

  // grant 0 = A, 1 = B; on contention the side that did not win last time
  assign w_pick = (w_a_req & w_b_req) ? ~r_last_grant : w_b_req;

  assign w_g_read  = r_grant ? b_read       : a_read;
  assign w_g_write = r_grant ? b_write      : a_write;
  assign w_g_addr  = r_grant ? b_address    : a_address;
  assign w_g_wdata = r_grant ? b_writedata  : a_writedata;
  assign w_g_be    = r_grant ? b_byteenable : a_byteenable;

  // a reset cycle never issues, acknowledges or answers anything
  assign w_in_bus = (r_state == S_BUS) & ~reset_reset;
  assign w_in_rd  = (r_state == S_RDWAIT) & ~reset_reset;

  assign w_ack   = w_in_bus & ~slave_waitrequest;
  assign w_tmo   = w_in_rd & ~slave_readdatavalid & (r_cnt == CNT_LAST);
  assign w_rsp   = w_in_rd & (slave_readdatavalid | w_tmo);
  assign w_rdata = slave_readdatavalid ? slave_readdata : FILL;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_a_req | w_b_req) w_next = S_BUS;
      end
      S_BUS: begin
        if (!(w_g_read | w_g_write)) w_next = S_IDLE;
        else if (!slave_waitrequest) w_next = w_g_write ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        if (slave_readdatavalid || r_cnt == CNT_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && (w_a_req | w_b_req)) begin
        r_grant      <= w_pick;
        r_last_grant <= w_pick;
      end
      if (r_state == S_RDWAIT) r_cnt <= r_cnt + CNT_W'(1);
      else r_cnt <= '0;
      if (w_tmo) r_err <= 1'b1;
    end
  end

  always_comb begin
    slave_read       = 1'b0;
    slave_write      = 1'b0;
    slave_address    = '0;
    slave_writedata  = '0;
    slave_byteenable = '0;
    if (w_in_bus) begin
      slave_write      = w_g_write;
      slave_read       = w_g_read & ~w_g_write;
      slave_address    = w_g_addr;
      slave_writedata  = w_g_wdata;
      slave_byteenable = w_g_be;
    end
  end

  always_comb begin
    a_waitrequest   = 1'b1;
    b_waitrequest   = 1'b1;
    a_readdatavalid = 1'b0;
    b_readdatavalid = 1'b0;
    a_readdata      = '0;
    b_readdata      = '0;
    if (w_ack) begin
      a_waitrequest = r_grant;
      b_waitrequest = ~r_grant;
    end
    if (w_rsp) begin
      if (r_grant) begin
        b_readdatavalid = 1'b1;
        b_readdata      = w_rdata;
      end else begin
        a_readdatavalid = 1'b1;
        a_readdata      = w_rdata;
      end
    end
  end

  assign slave_burstcount = 1'b1;
  assign rd_timeout_err   = r_err;

endmodule

// File: tb/tb_hdmi_mm_arbiter.sv
// tb_hdmi_mm_arbiter: directed stimulus, transaction-level response model
// checked every cycle, plus literal checks on latencies and grant order.
module tb_hdmi_mm_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] DEAD = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset_reset;
  logic a_read, a_write, b_read, b_write;
  logic [9:0] a_address, b_address, slave_address;
  logic [31:0] a_writedata, b_writedata, slave_writedata;
  logic [3:0] a_byteenable, b_byteenable, slave_byteenable;
  logic a_waitrequest, a_readdatavalid, b_waitrequest, b_readdatavalid;
  logic [31:0] a_readdata, b_readdata, slave_readdata;
  logic slave_read, slave_write, slave_burstcount;
  logic slave_waitrequest, slave_readdatavalid;
  logic rd_timeout_err;

  hdmi_mm_arbiter #(
    .ADDR_W(10),
    .DATA_W(32),
    .RD_TIMEOUT(TO)
  ) dut (
    .clk_clk(clk),
    .reset_reset(reset_reset),
    .a_read(a_read),
    .a_write(a_write),
    .a_address(a_address),
    .a_writedata(a_writedata),
    .a_byteenable(a_byteenable),
    .a_waitrequest(a_waitrequest),
    .a_readdatavalid(a_readdatavalid),
    .a_readdata(a_readdata),
    .b_read(b_read),
    .b_write(b_write),
    .b_address(b_address),
    .b_writedata(b_writedata),
    .b_byteenable(b_byteenable),
    .b_waitrequest(b_waitrequest),
    .b_readdatavalid(b_readdatavalid),
    .b_readdata(b_readdata),
    .slave_read(slave_read),
    .slave_write(slave_write),
    .slave_address(slave_address),
    .slave_writedata(slave_writedata),
    .slave_byteenable(slave_byteenable),
    .slave_burstcount(slave_burstcount),
    .slave_waitrequest(slave_waitrequest),
    .slave_readdatavalid(slave_readdatavalid),
    .slave_readdata(slave_readdata),
    .rd_timeout_err(rd_timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // response model: at most one read in flight, owner and age since accept
  bit m_pend = 0;
  bit m_owner = 0;
  int m_wait = 0;
  bit m_err = 0;

  logic s_awr, s_bwr, s_ardv, s_brdv, s_srd, s_swr, s_swait, s_err;
  logic [31:0] s_ard, s_brd, s_sdata;
  logic [9:0] s_saddr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model();
    bit ea, eb;
    logic [31:0] ed;
    ea = 0;
    eb = 0;
    ed = '0;
    chk("err_flag", rd_timeout_err, m_err);
    chk("burstcount", slave_burstcount, 1);
    if (m_pend && !reset_reset) begin
      chk("one_outstanding", {slave_read, slave_write}, 2'b00);
      m_wait++;
      if (slave_readdatavalid || m_wait == TO) begin
        ed = slave_readdatavalid ? slave_readdata : DEAD;
        if (!slave_readdatavalid) m_err = 1;
        if (m_owner) eb = 1;
        else ea = 1;
        m_pend = 0;
      end
    end
    chk("a_rdv", a_readdatavalid, ea);
    chk("b_rdv", b_readdatavalid, eb);
    chk("a_rdata", a_readdata, ea ? ed : 32'h0);
    chk("b_rdata", b_readdata, eb ? ed : 32'h0);
    if (!a_waitrequest) begin
      chk("a_ack_excl", b_waitrequest, 1);
      chk("a_ack_swait", slave_waitrequest, 0);
      if (a_write) begin
        chk("a_wr_cmd", {slave_write, slave_read}, 2'b10);
        chk("a_wr_addr", slave_address, a_address);
        chk("a_wr_data", slave_writedata, a_writedata);
        chk("a_wr_be", slave_byteenable, a_byteenable);
      end else if (a_read) begin
        chk("a_rd_cmd", {slave_write, slave_read}, 2'b01);
        chk("a_rd_addr", slave_address, a_address);
        m_pend = 1;
        m_owner = 0;
        m_wait = 0;
      end
    end
    if (!b_waitrequest) begin
      chk("b_ack_swait", slave_waitrequest, 0);
      if (b_write) begin
        chk("b_wr_cmd", {slave_write, slave_read}, 2'b10);
        chk("b_wr_addr", slave_address, b_address);
        chk("b_wr_data", slave_writedata, b_writedata);
        chk("b_wr_be", slave_byteenable, b_byteenable);
      end else if (b_read) begin
        chk("b_rd_cmd", {slave_write, slave_read}, 2'b01);
        chk("b_rd_addr", slave_address, b_address);
        m_pend = 1;
        m_owner = 1;
        m_wait = 0;
      end
    end
    if (reset_reset) begin
      m_pend = 0;
      m_err = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_awr = a_waitrequest;
    s_bwr = b_waitrequest;
    s_ardv = a_readdatavalid;
    s_brdv = b_readdatavalid;
    s_ard = a_readdata;
    s_brd = b_readdata;
    s_srd = slave_read;
    s_swr = slave_write;
    s_saddr = slave_address;
    s_sdata = slave_writedata;
    s_swait = slave_waitrequest;
    s_err = rd_timeout_err;
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_read = 0;
    a_write = 0;
    b_read = 0;
    b_write = 0;
    a_address = '0;
    b_address = '0;
    a_writedata = '0;
    b_writedata = '0;
    a_byteenable = 4'hF;
    b_byteenable = 4'hF;
    slave_waitrequest = 0;
    slave_readdatavalid = 0;
    slave_readdata = '0;
  endtask

  task automatic do_reset();
    reset_reset = 1;
    clear_inputs();
    tick();
    reset_reset = 0;
  endtask

  initial begin
    int acc_k, rdv_k, nacc, nstall, na, nb;
    bit exp_b;
    logic [31:0] rd;

    do_reset();
    tick();
    chk("rst_a_wait", s_awr, 1);
    chk("rst_b_wait", s_bwr, 1);
    chk("rst_slave_cmd", {s_srd, s_swr}, 2'b00);
    chk("rst_rdv", {s_ardv, s_brdv}, 2'b00);
    chk("rst_err", s_err, 0);

    // single write from A
    a_write = 1;
    a_address = 10'h005;
    a_writedata = 32'h00FF00FF;
    acc_k = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!s_awr) begin
        acc_k = k;
        break;
      end
    end
    a_write = 0;
    chk("wr_latency", acc_k, 1);
    chk("wr_slave_write", s_swr, 1);
    chk("wr_addr", s_saddr, 10'h005);
    chk("wr_data", s_sdata, 32'h00FF00FF);
    tick();
    chk("wr_back_idle", {s_swr, s_srd, s_awr}, 3'b001);

    // contention: both write continuously from reset
    do_reset();
    a_write = 1;
    a_address = 10'h001;
    a_writedata = 32'h11111111;
    b_write = 1;
    b_address = 10'h002;
    b_writedata = 32'h22222222;
    exp_b = 0;
    nacc = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (!s_awr || !s_bwr) begin
        chk("rr_grant", {s_awr, s_bwr}, exp_b ? 2'b10 : 2'b01);
        exp_b = ~exp_b;
        nacc++;
      end
    end
    a_write = 0;
    b_write = 0;
    chk("rr_count", nacc, 8);
    tick();

    // B read stalled by slave for 3 cycles, data 2 cycles after accept
    slave_waitrequest = 1;
    b_read = 1;
    b_address = 10'h3FF;
    acc_k = -100;
    rdv_k = -1;
    nacc = 0;
    nstall = 0;
    na = 0;
    nb = 0;
    rd = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (s_srd && s_swait) begin
        nstall++;
        if (nstall == 3) slave_waitrequest = 0;
      end
      if (!s_bwr) begin
        nacc++;
        b_read = 0;
        acc_k = k;
      end
      if (s_brdv) begin
        nb++;
        rd = s_brd;
        rdv_k = k;
      end
      if (s_ardv) na++;
      slave_readdatavalid = (k == acc_k + 1);
      slave_readdata = (k == acc_k + 1) ? 32'h12345678 : 32'h0;
    end
    chk("rd_stalls", nstall, 3);
    chk("rd_b_ack_once", nacc, 1);
    chk("rd_b_rdv_once", nb, 1);
    chk("rd_b_data", rd, 32'h12345678);
    chk("rd_rdv_delay", rdv_k - acc_k, 2);
    chk("rd_a_rdv_none", na, 0);

    // A read with no response: timeout, then a late response is dropped
    a_read = 1;
    a_address = 10'h007;
    acc_k = -100;
    rdv_k = -100;
    na = 0;
    rd = '0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (!s_awr) begin
        a_read = 0;
        acc_k = k;
      end
      if (s_ardv) begin
        na++;
        rd = s_ard;
        rdv_k = k;
      end
      slave_readdatavalid = (k == rdv_k);
      slave_readdata = (k == rdv_k) ? 32'hCAFEF00D : 32'h0;
    end
    chk("tmo_delay", rdv_k - acc_k, TO);
    chk("tmo_data", rd, DEAD);
    chk("tmo_pulse_once", na, 1);
    chk("tmo_err_set", s_err, 1);

    b_write = 1;
    b_address = 10'h010;
    b_writedata = 32'h0BADC0DE;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_bwr) break;
    end
    b_write = 0;
    tick();
    chk("tmo_err_sticky", s_err, 1);
    do_reset();
    tick();
    chk("tmo_err_cleared", s_err, 0);

    // reset while A's read is waiting for data
    a_read = 1;
    a_address = 10'h020;
    acc_k = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_awr) begin
        acc_k = k;
        break;
      end
    end
    a_read = 0;
    chk("mid_rd_accept", acc_k, 1);
    reset_reset = 1;
    tick();
    reset_reset = 0;
    slave_readdatavalid = 1;
    slave_readdata = 32'h55AA55AA;
    tick();
    slave_readdatavalid = 0;
    chk("mid_rst_wait", {s_awr, s_bwr}, 2'b11);
    chk("mid_rst_cmd", {s_srd, s_swr}, 2'b00);
    chk("mid_rst_rdv", {s_ardv, s_brdv}, 2'b00);
    chk("mid_rst_err", s_err, 0);
    a_write = 1;
    b_write = 1;
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_awr || !s_bwr) begin
        chk("mid_rst_first_grant", {s_awr, s_bwr}, 2'b01);
        nacc++;
        break;
      end
    end
    a_write = 0;
    b_write = 0;
    chk("mid_rst_grant_seen", nacc, 1);
    tick();

    // A asserts read and write together: write only
    a_read = 1;
    a_write = 1;
    a_address = 10'h009;
    a_writedata = 32'hAAAA5555;
    acc_k = -1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (!s_awr) begin
        acc_k = k;
        break;
      end
    end
    a_read = 0;
    a_write = 0;
    chk("rw_accept", acc_k, 1);
    chk("rw_cmd", {s_swr, s_srd}, 2'b10);
    chk("rw_data", s_sdata, 32'hAAAA5555);
    na = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_ardv || s_srd || s_swr) na++;
    end
    chk("rw_no_rdv", na, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
